// File: rtl/instr_loader_pkg.sv
// rtl/instr_loader_pkg.sv - shared states, header size and lane helper for the instruction loader
package instr_loader_pkg;

    typedef enum logic [2:0] {
        HDR  = 3'd0,
        LOAD = 3'd1,
        HOLD = 3'd2,
        RUN  = 3'd3,
        ERR  = 3'd4,
        CSUM = 3'd5
    } state_t;

    localparam int HDR_BYTES = 4;

    function automatic int byte_lanes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/instr_loader_byte_packer.sv
// rtl/instr_loader_byte_packer.sv - assembles little-endian bytes into RAM words
module instr_loader_byte_packer
    import instr_loader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              accept,
    input  logic [7:0]        in_data,
    output logic              lane_last,
    output logic              word_valid,
    output logic [DATA_W-1:0] word
);

    localparam int LANES  = byte_lanes(DATA_W);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LANE_END = LANE_W'(LANES - 1);

    logic [LANE_W-1:0] lane;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_next;

    assign lane_last = (lane == LANE_END);

    // Drop the incoming byte into its lane of the partial word
    always_comb begin
        acc_next = acc;
        for (int k = 0; k < LANES; k++) begin
            if (lane == LANE_W'(k)) begin
                acc_next[8*k +: 8] = in_data;
            end
        end
    end

    // Advance the lane counter; publish the finished word with a one-cycle pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            lane       <= '0;
            acc        <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (accept) begin
                acc <= acc_next;
                if (lane_last) begin
                    lane       <= '0;
                    word       <= acc_next;
                    word_valid <= 1'b1;
                end else begin
                    lane <= lane + LANE_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - boot byte-stream loader for instruction RAM; INSTR_LOADER_CSUM_EN adds a trailing XOR checksum byte
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int HOLD_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              err
);

`ifdef INSTR_LOADER_CSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    localparam int HOLD_W = $clog2(HOLD_CYC + 1);
    localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(HOLD_CYC);
    localparam logic [32:0]       DEPTH    = 33'd1 << ADDR_W;
    localparam logic [1:0]        HDR_END  = 2'(HDR_BYTES - 1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

    state_t            state;
    logic [1:0]        hdr_cnt;
    logic [23:0]       hdr_sr;
    logic [31:0]       hdr_word;
    logic [ADDR_W:0]   n_words;
    logic [ADDR_W:0]   word_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [7:0]        csum;
    logic              accept;
    logic              lane_last;
    logic              last_word;

    assign accept    = in_valid && in_ready;
    assign hdr_word  = {in_data, hdr_sr};
    assign last_word = (word_cnt + CNT_ONE) == n_words;

    instr_loader_byte_packer #(
        .DATA_W (DATA_W)
    ) u_byte_packer (
        .clk        (clk),
        .rst        (rst),
        .accept     (accept && (state == LOAD)),
        .in_data    (in_data),
        .lane_last  (lane_last),
        .word_valid (ram_we),
        .word       (ram_wdata)
    );

    // Load sequencer: header, payload, optional checksum, reset hold, then release
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HDR;
            in_ready <= 1'b0;
            core_rst <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            hdr_cnt  <= '0;
            hdr_sr   <= '0;
            n_words  <= '0;
            word_cnt <= '0;
            ram_addr <= '0;
            hold_cnt <= '0;
            csum     <= '0;
        end else begin
            case (state)
                HDR: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        hdr_sr  <= {in_data, hdr_sr[23:8]};
                        hdr_cnt <= hdr_cnt + 2'd1;
                        if (hdr_cnt == HDR_END) begin
                            if (hdr_word == 32'd0) begin
                                hold_cnt <= '0;
                                in_ready <= CSUM_EN;
                                state    <= CSUM_EN ? CSUM : HOLD;
                            end else if ({1'b0, hdr_word} > DEPTH) begin
                                in_ready <= 1'b0;
                                err      <= 1'b1;
                                state    <= ERR;
                            end else begin
                                n_words <= hdr_word[ADDR_W:0];
                                state   <= LOAD;
                            end
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        csum <= csum ^ in_data;
                        if (lane_last) begin
                            ram_addr <= word_cnt[ADDR_W-1:0];
                            word_cnt <= word_cnt + CNT_ONE;
                            if (last_word) begin
                                hold_cnt <= '0;
                                in_ready <= CSUM_EN;
                                state    <= CSUM_EN ? CSUM : HOLD;
                            end
                        end
                    end
                end
                CSUM: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        hold_cnt <= '0;
                        if (in_data == csum) begin
                            state <= HOLD;
                        end else begin
                            err   <= 1'b1;
                            state <= ERR;
                        end
                    end
                end
                HOLD: begin
                    in_ready <= 1'b0;
                    if (hold_cnt == HOLD_END) begin
                        core_rst <= 1'b0;
                        done     <= 1'b1;
                        state    <= RUN;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                RUN: begin
                    in_ready <= 1'b0;
                    core_rst <= 1'b0;
                    done     <= 1'b1;
                end
                ERR: begin
                    in_ready <= 1'b0;
                    core_rst <= 1'b1;
                    done     <= 1'b0;
                    err      <= 1'b1;
                end
                default: begin
                    in_ready <= 1'b0;
                    err      <= 1'b1;
                    state    <= ERR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - self-checking bench for instr_loader
module tb_instr_loader;

    localparam int ADDR_W   = 2;
    localparam int DATA_W   = 32;
    localparam int HOLD_CYC = 4;
    localparam int L        = DATA_W / 8;
    localparam int DEPTH    = 1 << ADDR_W;

`ifdef INSTR_LOADER_CSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              core_rst;
    logic              done;
    logic              err;

    int total = 0;
    int bad   = 0;

    logic [ADDR_W-1:0] wr_addr[$];
    logic [DATA_W-1:0] wr_data[$];
    logic [7:0]        payload_q[$];
    longint            acc_t  = 0;
    longint            fall_t = 0;
    logic              prev_crst = 1'b1;
    int                mark = 0;

    typedef struct {
        logic [31:0] hdr;
        int          gap_hi;
        bit          bad_csum;
        bit          exp_err;
        int          exp_nw;
    } vec_t;

    vec_t tbl[7];

    instr_loader #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .HOLD_CYC (HOLD_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .core_rst  (core_rst),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (prev_crst && !core_rst) fall_t = $time - 5;
        prev_crst = core_rst;
        if (ram_we) begin
            wr_addr.push_back(ram_addr);
            wr_data.push_back(ram_wdata);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        guard    = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check("send_ready_timeout", {63'd0, in_ready}, 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        acc_t = $time;
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_end(input string nm);
        int guard = 0;
        while (!(done || err) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        check({nm, ".finished"}, {63'd0, done | err}, 64'd1);
    endtask

    // Sends header + payload_q (+checksum), then checks against the model
    task automatic run_load(input string nm, input logic [31:0] hdr, input int gap_lo,
                            input int gap_hi, input bit bad_csum, input bit exp_err,
                            input int exp_nw);
        logic [DATA_W-1:0] expw[$];
        logic [DATA_W-1:0] w;
        logic [7:0]        x;
        bit                eff_err;
        int                got_nw;
        do_reset();
        mark = wr_addr.size();
        x = 8'h00;
        for (int wi = 0; wi < payload_q.size() / L; wi++) begin
            w = '0;
            for (int k = 0; k < L; k++) begin
                w = w | (DATA_W'(payload_q[wi*L + k]) << (8 * k));
                x = x ^ payload_q[wi*L + k];
            end
            expw.push_back(w);
        end
        eff_err = exp_err || (CSUM_EN && bad_csum);
        for (int k = 0; k < 4; k++) send_byte(hdr[8*k +: 8], 0);
        if (!exp_err) begin
            foreach (payload_q[i]) send_byte(payload_q[i], $urandom_range(gap_hi, gap_lo));
`ifdef INSTR_LOADER_CSUM_EN
            send_byte(bad_csum ? (x ^ 8'h01) : x, 0);
`endif
        end
        wait_end(nm);
        check({nm, ".err"}, {63'd0, err}, {63'd0, eff_err});
        check({nm, ".done"}, {63'd0, done}, {63'd0, !eff_err});
        check({nm, ".core_rst"}, {63'd0, core_rst}, {63'd0, eff_err});
        check({nm, ".in_ready"}, {63'd0, in_ready}, 64'd0);
        got_nw = wr_addr.size() - mark;
        check({nm, ".nwrites"}, 64'(got_nw), 64'(exp_nw));
        for (int i = 0; i < got_nw && i < exp_nw && i < expw.size(); i++) begin
            check($sformatf("%s.addr%0d", nm, i), 64'(wr_addr[mark + i]), 64'(i));
            check($sformatf("%s.data%0d", nm, i), 64'(wr_data[mark + i]), 64'(expw[i]));
        end
        if (!eff_err) check({nm, ".latency"}, 64'(fall_t - acc_t), 64'((1 + HOLD_CYC) * 10));
    endtask

    initial begin
        logic [7:0]        nb;
        logic [DATA_W-1:0] neww;
        int                m2;

        tbl[0] = '{32'd1,          0, 1'b0, 1'b0, 1};
        tbl[1] = '{32'd4,          2, 1'b0, 1'b0, 4};
        tbl[2] = '{32'd5,          0, 1'b0, 1'b1, 0};
        tbl[3] = '{32'd0,          0, 1'b0, 1'b0, 0};
        tbl[4] = '{32'h0001_0000,  0, 1'b0, 1'b1, 0};
        tbl[5] = '{32'h8000_0004,  0, 1'b0, 1'b1, 0};
        tbl[6] = '{32'd2,          1, 1'b1, 1'b0, 2};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst.in_ready",  {63'd0, in_ready}, 64'd0);
        check("rst.ram_we",    {63'd0, ram_we},   64'd0);
        check("rst.ram_addr",  64'(ram_addr),     64'd0);
        check("rst.ram_wdata", 64'(ram_wdata),    64'd0);
        check("rst.core_rst",  {63'd0, core_rst}, 64'd1);
        check("rst.done",      {63'd0, done},     64'd0);
        check("rst.err",       {63'd0, err},      64'd0);

        payload_q = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00,
                      8'h33, 8'h06, 8'hb5, 8'h00};
        run_load("basic", 32'd3, 0, 0, 1'b0, 1'b0, 3);
        check("basic.w0", 64'(wr_data[mark + 0]), 64'h0010_0513);
        check("basic.w1", 64'(wr_data[mark + 1]), 64'h0020_0593);
        check("basic.w2", 64'(wr_data[mark + 2]), 64'h00b5_0633);

        payload_q.delete();
        run_load("empty", 32'd0, 0, 0, 1'b0, 1'b0, 0);

        run_load("oversize", 32'd5, 0, 0, 1'b0, 1'b1, 0);

        payload_q.delete();
        for (int i = 0; i < 2 * L; i++) payload_q.push_back(8'($urandom_range(0, 255)));
        run_load("stall", 32'd2, 1, 1, 1'b0, 1'b0, 2);

        for (int t = 0; t < 7; t++) begin
            payload_q.delete();
            if (!tbl[t].exp_err)
                for (int i = 0; i < int'(tbl[t].hdr) * L; i++)
                    payload_q.push_back(8'($urandom_range(0, 255)));
            run_load($sformatf("vec%0d", t), tbl[t].hdr, 0, tbl[t].gap_hi,
                     tbl[t].bad_csum, tbl[t].exp_err, tbl[t].exp_nw);
        end

        do_reset();
        for (int k = 0; k < 4; k++) send_byte(8'(k == 0 ? 2 : 0), 0);
        for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(0, 255)), 0);
        do_reset();
        m2   = wr_addr.size();
        neww = DATA_W'($urandom);
        nb   = 8'h00;
        send_byte(8'd1, 0);
        for (int k = 1; k < 4; k++) send_byte(8'd0, 0);
        for (int k = 0; k < L; k++) begin
            send_byte(neww[8*k +: 8], 0);
            nb = nb ^ neww[8*k +: 8];
        end
`ifdef INSTR_LOADER_CSUM_EN
        send_byte(nb, 0);
`endif
        wait_end("midrst");
        check("midrst.nwrites", 64'(wr_addr.size() - m2), 64'd1);
        if (wr_addr.size() > m2) begin
            check("midrst.addr", 64'(wr_addr[m2]), 64'd0);
            check("midrst.data", 64'(wr_data[m2]), 64'(neww));
        end
        check("midrst.done", {63'd0, done}, 64'd1);
        check("midrst.err",  {63'd0, err},  64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Boot-time instruction-RAM loader for the SoC.
- Replaces simulation-only memory preload with a synthesizable byte-stream load path: receives a length header plus payload bytes, assembles little-endian words, and writes them into the instruction RAM port.
- Holds the core in reset until loading completes, then releases it after a programmable hold delay.
- Generalised over word width, RAM depth and hold time; sits between the boot byte source (UART RX / debug bridge / bench) and mem_controller's instruction RAM write port.

Parameters:
ADDR_W, 10, instruction RAM word-address width; depth = 2**ADDR_W words
DATA_W, 32, RAM word width in bits; must be a multiple of 8, range 8..64
HOLD_CYC, 4, cycles core_rst stays asserted after the last RAM write; must be >= 1

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  byte-stream valid
in_data  input  8  byte-stream data
in_ready  output  1  byte accepted when in_valid && in_ready at a rising edge
ram_we  output  1  instruction RAM write strobe, one cycle per word
ram_addr  output  ADDR_W  RAM word address
ram_wdata  output  DATA_W  RAM write data
core_rst  output  1  active-high reset to the core
done  output  1  load complete, core released
err  output  1  load aborted; sticky until rst

Behaviour:
- Reset values: in_ready=0, ram_we=0, ram_addr=0, ram_wdata=0, core_rst=1, done=0, err=0. State is HDR; all counters are zero.
- Reset asserted mid-operation aborts the load. Partially written RAM contents stay in place; the loader restarts in HDR.
- States: HDR, LOAD, HOLD, RUN, ERR. in_ready=1 only in HDR and LOAD.
- HDR: accepts 4 bytes, little-endian, forming a 32-bit word count N.
  - On the 4th byte, if N==0, go to HOLD.
  - If N > 2**ADDR_W, go to ERR.
  - Otherwise go to LOAD.
- LOAD: accepts DATA_W/8 bytes per word; byte k goes to ram_wdata[8k+7:8k].
  - The cycle after the last byte of a word is accepted: ram_we=1 for exactly one cycle, ram_addr = word index (starting at 0, incrementing by 1), ram_wdata = the assembled word.
  - After word N-1 is written, go to HOLD. in_ready drops in the cycle the final byte is accepted.
  - Bytes with in_valid=0 stall assembly indefinitely; there is no timeout.
  - ram_addr never wraps, because N <= depth is enforced in HDR.
- HOLD: counts HOLD_CYC cycles with core_rst=1, then goes to RUN.
- RUN: core_rst=0, done=1. Terminal until rst; input bytes are not accepted.
- ERR: err=1, core_rst=1, done=0. Terminal until rst.
- ram_we is never asserted outside LOAD and the cycle immediately after it.
- Total latency, last byte accepted to core_rst falling: 1 + HOLD_CYC cycles.

Optional Feature:
- Macro: INSTR_LOADER_CSUM_EN
- Defined:
  - After the payload (or directly after the header if N==0), one extra checksum byte is accepted in a CSUM state.
  - Expected value: XOR of all payload bytes (0x00 when N==0).
  - Match: go to HOLD. Mismatch: go to ERR.
  - The last RAM write still happens before the check.
- Undefined: no CSUM state, and no byte is consumed after the payload.

Decomposition:
- Package instr_loader_pkg holds:
  - the state enum localparams (HDR, LOAD, HOLD, RUN, ERR, CSUM);
  - the header length constant HDR_BYTES=4;
  - the byte-lane count function DATA_W/8.
- One natural sub-module: byte_packer. It shifts bytes into a DATA_W word, counts lanes, and emits a word_valid pulse.
- FSM and counters stay in instr_loader.

Test Plan:
- Basic load, DATA_W=32: header 03 00 00 00, then payload 13 05 10 00 | 93 05 20 00 | 33 06 b5 00 -> three ram_we pulses: addr 0 = 0x00100513, addr 1 = 0x00200593, addr 2 = 0x00b50633. core_rst falls exactly 1+4 cycles after the last byte; done=1.
- Empty program: header 00 00 00 00 -> no ram_we; core_rst falls 5 cycles after the 4th byte.
- Oversize, ADDR_W=2: header 05 00 00 00 -> err=1, in_ready=0, core_rst stays 1, no ram_we.
- Stalled source: toggle in_valid every other cycle across a 2-word load -> same RAM writes as the unstalled case; no byte is dropped or duplicated.
- Mid-load reset: rst pulsed after 6 payload bytes, then a full 1-word reload -> the single write goes to addr 0 with the new data; done=1.
- With INSTR_LOADER_CSUM_EN: correct checksum byte -> done=1. Corrupted checksum byte -> err=1 and core_rst stays 1.
